// File: rtl/rf_pkg.sv
// Shared sizing and requester-index constants for the integer register-file write-back path.
package rf_pkg;
    localparam int RF_XLEN = 32;
    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;
    localparam int REQ_ALU = 0;
    localparam int REQ_LD  = 1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester write-back arbiter: round-robin between ALU and load, or fixed load priority.
module rr_arb2
    import rf_pkg::*;
#(
    parameter int LD_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic ptr_ld;  // 1: load wins the next tie

    always_comb begin
        grant = 2'b00;
        if (req[REQ_LD] && req[REQ_ALU]) begin
            if ((LD_PRIO != 0) || ptr_ld) grant[REQ_LD] = 1'b1;
            else                          grant[REQ_ALU] = 1'b1;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               ptr_ld <= 1'b1;
        else if (grant[REQ_LD])   ptr_ld <= 1'b0;
        else if (grant[REQ_ALU])  ptr_ld <= 1'b1;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back controller: arbitrates ALU/load results onto the single
// write port and tracks pending loads so decode can stall on their destinations.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN    = RF_XLEN,
    parameter int LD_PRIO = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [REG_AW-1:0]   ld_rd,
    input  logic [XLEN-1:0]     ld_data,
    input  logic                ld_issue,
    input  logic [REG_AW-1:0]   ld_issue_rd,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [REG_AW-1:0]   rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                we3,
    output logic [REG_AW-1:0]   a3,
    output logic [XLEN-1:0]     wd3,
    output logic [REG_CNT-1:0]  busy_vec,
    output logic                err
);
    logic [1:0]         req;
    logic [1:0]         grant;
    logic               wb_is_ld;
    logic [REG_CNT-1:0] busy;
    logic [REG_CNT-1:0] busy_next;
    logic               clr_hit;
    logic               waw_hit;
    logic               orphan_hit;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_LD]  = ld_valid;

    rr_arb2 #(.LD_PRIO(LD_PRIO)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant)
    );

    assign alu_ready = grant[REQ_ALU];
    assign ld_ready  = grant[REQ_LD];

    // Grant edge -> registered write port (one cycle of latency)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3      <= 1'b0;
            a3       <= '0;
            wd3      <= '0;
            wb_is_ld <= 1'b0;
        end else if (ld_ready) begin
            we3      <= (ld_rd != '0);
            a3       <= ld_rd;
            wd3      <= ld_data;
            wb_is_ld <= 1'b1;
        end else if (alu_ready) begin
            we3      <= (alu_rd != '0);
            a3       <= alu_rd;
            wd3      <= alu_data;
            wb_is_ld <= 1'b0;
        end else begin
            we3      <= 1'b0;
            wb_is_ld <= 1'b0;
        end
    end

    // A pending bit drops on the same edge the register file commits the load data
    assign clr_hit = we3 && wb_is_ld;

    always_comb begin
        busy_next = busy;
        if (clr_hit) busy_next[a3] = 1'b0;
        if (ld_issue && (ld_issue_rd != '0)) busy_next[ld_issue_rd] = 1'b1;
    end

    assign waw_hit    = ld_issue && (ld_issue_rd != '0) && busy[ld_issue_rd]
                        && !(clr_hit && (a3 == ld_issue_rd));
    assign orphan_hit = ld_ready && (ld_rd != '0) && !busy[ld_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_next;
            if (waw_hit || orphan_hit) err <= 1'b1;
        end
    end

    assign busy_vec = busy;
    assign rs1_busy = (rs1 != '0) && busy[rs1];
    assign rs2_busy = (rs2 != '0) && busy[rs2];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: one round-robin and one load-priority instance, directed
// scenarios with literal expectations, then random traffic against a behavioural model.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        s_alu_valid [2];
    logic [4:0]  s_alu_rd    [2];
    logic [31:0] s_alu_data  [2];
    logic        s_ld_valid  [2];
    logic [4:0]  s_ld_rd     [2];
    logic [31:0] s_ld_data   [2];
    logic        s_ld_issue  [2];
    logic [4:0]  s_ld_issue_rd [2];
    logic [4:0]  s_rs1 [2];
    logic [4:0]  s_rs2 [2];

    logic        alu_ready [2];
    logic        ld_ready  [2];
    logic        rs1_busy  [2];
    logic        rs2_busy  [2];
    logic        we3       [2];
    logic [4:0]  a3        [2];
    logic [31:0] wd3       [2];
    logic [31:0] busy_vec  [2];
    logic        err       [2];

    int checks = 0;
    int failures = 0;

    rf_wb_arbiter #(.XLEN(32), .LD_PRIO(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(s_alu_valid[0]), .alu_ready(alu_ready[0]), .alu_rd(s_alu_rd[0]), .alu_data(s_alu_data[0]),
        .ld_valid(s_ld_valid[0]), .ld_ready(ld_ready[0]), .ld_rd(s_ld_rd[0]), .ld_data(s_ld_data[0]),
        .ld_issue(s_ld_issue[0]), .ld_issue_rd(s_ld_issue_rd[0]),
        .rs1(s_rs1[0]), .rs2(s_rs2[0]), .rs1_busy(rs1_busy[0]), .rs2_busy(rs2_busy[0]),
        .we3(we3[0]), .a3(a3[0]), .wd3(wd3[0]), .busy_vec(busy_vec[0]), .err(err[0])
    );

    rf_wb_arbiter #(.XLEN(32), .LD_PRIO(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(s_alu_valid[1]), .alu_ready(alu_ready[1]), .alu_rd(s_alu_rd[1]), .alu_data(s_alu_data[1]),
        .ld_valid(s_ld_valid[1]), .ld_ready(ld_ready[1]), .ld_rd(s_ld_rd[1]), .ld_data(s_ld_data[1]),
        .ld_issue(s_ld_issue[1]), .ld_issue_rd(s_ld_issue_rd[1]),
        .rs1(s_rs1[1]), .rs2(s_rs2[1]), .rs1_busy(rs1_busy[1]), .rs2_busy(rs2_busy[1]),
        .we3(we3[1]), .a3(a3[1]), .wd3(wd3[1]), .busy_vec(busy_vec[1]), .err(err[1])
    );

    // Behavioural model state per instance (instance 1 is load-priority)
    bit [31:0] m_busy [2];
    bit        m_err  [2];
    bit        m_we3  [2];
    bit [4:0]  m_a3   [2];
    bit [31:0] m_wd3  [2];
    bit        m_isld [2];
    bit        m_last_ld [2];
    bit        m_gl [2];
    bit        m_ga [2];

    function automatic void exp_grant(input int i, output bit ga, output bit gl);
        ga = 1'b0;
        gl = 1'b0;
        if (s_alu_valid[i] && s_ld_valid[i]) begin
            if (i == 1 || !m_last_ld[i]) gl = 1'b1;
            else                         ga = 1'b1;
        end else begin
            ga = s_alu_valid[i];
            gl = s_ld_valid[i];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_busy[i] <= '0; m_err[i] <= 1'b0; m_we3[i] <= 1'b0; m_a3[i] <= '0;
                m_wd3[i] <= '0; m_isld[i] <= 1'b0; m_last_ld[i] <= 1'b0;
                m_gl[i] <= 1'b0; m_ga[i] <= 1'b0;
            end else begin : upd
                bit ga, gl, clr, e;
                bit [31:0] nb;
                exp_grant(i, ga, gl);
                nb  = m_busy[i];
                e   = m_err[i];
                clr = m_we3[i] && m_isld[i];
                if (clr) nb[m_a3[i]] = 1'b0;
                if (s_ld_issue[i] && s_ld_issue_rd[i] != 5'd0) begin
                    if (m_busy[i][s_ld_issue_rd[i]] && !(clr && m_a3[i] == s_ld_issue_rd[i])) e = 1'b1;
                    nb[s_ld_issue_rd[i]] = 1'b1;
                end
                if (gl && s_ld_rd[i] != 5'd0 && !m_busy[i][s_ld_rd[i]]) e = 1'b1;
                m_busy[i] <= nb;
                m_err[i]  <= e;
                m_gl[i]   <= gl;
                m_ga[i]   <= ga;
                if (gl) begin
                    m_we3[i] <= (s_ld_rd[i] != 5'd0); m_a3[i] <= s_ld_rd[i];
                    m_wd3[i] <= s_ld_data[i]; m_isld[i] <= 1'b1; m_last_ld[i] <= 1'b1;
                end else if (ga) begin
                    m_we3[i] <= (s_alu_rd[i] != 5'd0); m_a3[i] <= s_alu_rd[i];
                    m_wd3[i] <= s_alu_data[i]; m_isld[i] <= 1'b0; m_last_ld[i] <= 1'b0;
                end else begin
                    m_we3[i] <= 1'b0; m_isld[i] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        bit ga, gl;
        for (int i = 0; i < 2; i++) begin
            exp_grant(i, ga, gl);
            chk($sformatf("alu_ready[%0d]", i), 64'(alu_ready[i]), 64'(ga));
            chk($sformatf("ld_ready[%0d]", i), 64'(ld_ready[i]), 64'(gl));
            chk($sformatf("we3[%0d]", i), 64'(we3[i]), 64'(m_we3[i]));
            chk($sformatf("a3[%0d]", i), 64'(a3[i]), 64'(m_a3[i]));
            chk($sformatf("wd3[%0d]", i), 64'(wd3[i]), 64'(m_wd3[i]));
            chk($sformatf("busy_vec[%0d]", i), 64'(busy_vec[i]), 64'(m_busy[i]));
            chk($sformatf("err[%0d]", i), 64'(err[i]), 64'(m_err[i]));
            chk($sformatf("rs1_busy[%0d]", i), 64'(rs1_busy[i]),
                64'((s_rs1[i] != 5'd0) && m_busy[i][s_rs1[i]]));
            chk($sformatf("rs2_busy[%0d]", i), 64'(rs2_busy[i]),
                64'((s_rs2[i] != 5'd0) && m_busy[i][s_rs2[i]]));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
        #1;
    endtask

    task automatic idle(input int i);
        s_alu_valid[i] = 1'b0; s_alu_rd[i] = '0; s_alu_data[i] = '0;
        s_ld_valid[i] = 1'b0; s_ld_rd[i] = '0; s_ld_data[i] = '0;
        s_ld_issue[i] = 1'b0; s_ld_issue_rd[i] = '0; s_rs1[i] = '0; s_rs2[i] = '0;
    endtask

    task automatic drive_rand(input int i);
        if (!s_alu_valid[i] || m_ga[i]) begin
            s_alu_valid[i] = ($urandom_range(0, 3) != 0);
            s_alu_rd[i]    = 5'($urandom_range(0, 31));
            s_alu_data[i]  = $urandom;
        end
        if (!s_ld_valid[i] || m_gl[i]) begin
            s_ld_valid[i] = ($urandom_range(0, 2) == 0);
            s_ld_rd[i]    = 5'($urandom_range(0, 7));
            s_ld_data[i]  = $urandom;
        end
        s_ld_issue[i]    = ($urandom_range(0, 3) == 0);
        s_ld_issue_rd[i] = 5'($urandom_range(0, 7));
        s_rs1[i] = 5'($urandom_range(0, 7));
        s_rs2[i] = 5'($urandom_range(0, 7));
    endtask

    initial begin
        rst_n = 1'b0;
        idle(0);
        idle(1);
        tick(); tick();
        chk("reset_we3", 64'(we3[0]), 64'(0));
        chk("reset_busy", 64'(busy_vec[0]), 64'(0));
        chk("reset_err", 64'(err[0]), 64'(0));
        rst_n = 1'b1;

        // Scoreboard on r7: set, visible through rs1, cleared the edge after the write
        s_ld_issue[0] = 1'b1; s_ld_issue_rd[0] = 5'd7;
        tick();
        s_ld_issue[0] = 1'b0; s_rs1[0] = 5'd7; #1;
        chk("sb_busy7_set", 64'(busy_vec[0][7]), 64'(1));
        chk("sb_rs1_busy", 64'(rs1_busy[0]), 64'(1));
        chk("sb_rs2_x0", 64'(rs2_busy[0]), 64'(0));
        s_ld_valid[0] = 1'b1; s_ld_rd[0] = 5'd7; s_ld_data[0] = 32'h0000_0077; #1;
        chk("sb_ld_ready", 64'(ld_ready[0]), 64'(1));
        tick();
        s_ld_valid[0] = 1'b0;
        chk("sb_we3", 64'(we3[0]), 64'(1));
        chk("sb_a3", 64'(a3[0]), 64'(7));
        chk("sb_busy7_during_we", 64'(busy_vec[0][7]), 64'(1));
        tick();
        chk("sb_busy7_cleared", 64'(busy_vec[0][7]), 64'(0));
        chk("sb_rs1_free", 64'(rs1_busy[0]), 64'(0));
        chk("sb_err_clean", 64'(err[0]), 64'(0));

        // x0 write is accepted but never enables the port
        s_rs1[0] = 5'd0;
        s_alu_valid[0] = 1'b1; s_alu_rd[0] = 5'd0; s_alu_data[0] = 32'h0000_1234; #1;
        chk("x0_alu_ready", 64'(alu_ready[0]), 64'(1));
        tick();
        s_alu_valid[0] = 1'b0;
        chk("x0_we3", 64'(we3[0]), 64'(0));
        chk("x0_wd3", 64'(wd3[0]), 64'(32'h1234));

        // WAW on a pending load sets sticky err
        s_ld_issue[0] = 1'b1; s_ld_issue_rd[0] = 5'd3;
        tick();
        chk("waw_first_ok", 64'(err[0]), 64'(0));
        tick();
        s_ld_issue[0] = 1'b0;
        chk("waw_err", 64'(err[0]), 64'(1));
        s_alu_valid[0] = 1'b1; s_alu_rd[0] = 5'd9; s_alu_data[0] = 32'd5;
        tick();
        chk("waw_err_sticky", 64'(err[0]), 64'(1));
        chk("pre_rst_we3", 64'(we3[0]), 64'(1));

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2;
        s_alu_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_we3", 64'(we3[0]), 64'(0));
        chk("async_busy", 64'(busy_vec[0]), 64'(0));
        chk("async_err", 64'(err[0]), 64'(0));
        tick();
        rst_n = 1'b1;

        // First request after reset; r5 is not pending so it is also an orphan
        s_ld_valid[0] = 1'b1; s_ld_rd[0] = 5'd5; s_ld_data[0] = 32'hDEAD_BEEF; #1;
        chk("post_rst_ld_ready", 64'(ld_ready[0]), 64'(1));
        tick();
        s_ld_valid[0] = 1'b0;
        chk("post_rst_we3", 64'(we3[0]), 64'(1));
        chk("post_rst_a3", 64'(a3[0]), 64'(5));
        chk("post_rst_wd3", 64'(wd3[0]), 64'(32'hDEAD_BEEF));
        chk("orphan_err", 64'(err[0]), 64'(1));

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Round-robin contention: load first after reset, then alternate
        s_ld_issue[0] = 1'b1; s_ld_issue_rd[0] = 5'd2;
        tick(); tick();
        s_ld_issue[0] = 1'b0;
        s_alu_valid[0] = 1'b1; s_alu_rd[0] = 5'd1; s_alu_data[0] = 32'hA1;
        s_ld_valid[0]  = 1'b1; s_ld_rd[0]  = 5'd2; s_ld_data[0]  = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_ld_ready_%0d", k), 64'(ld_ready[0]), 64'((k % 2) == 0));
            chk($sformatf("rr_alu_ready_%0d", k), 64'(alu_ready[0]), 64'((k % 2) == 1));
            tick();
            chk($sformatf("rr_a3_%0d", k), 64'(a3[0]), 64'(((k % 2) == 0) ? 2 : 1));
            chk($sformatf("rr_we3_%0d", k), 64'(we3[0]), 64'(1));
        end
        idle(0);

        // Fixed priority: load wins every cycle
        s_alu_valid[1] = 1'b1; s_alu_rd[1] = 5'd10; s_alu_data[1] = 32'hC3;
        s_ld_valid[1]  = 1'b1; s_ld_rd[1]  = 5'd11; s_ld_data[1]  = 32'hD4;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("prio_ld_ready_%0d", k), 64'(ld_ready[1]), 64'(1));
            chk($sformatf("prio_alu_ready_%0d", k), 64'(alu_ready[1]), 64'(0));
            tick();
            chk($sformatf("prio_a3_%0d", k), 64'(a3[1]), 64'(11));
        end
        idle(1);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3000) begin
            drive_rand(0);
            drive_rand(1);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
